// File: rtl/vram_arb.sv
// Two-requester arbiter for the video RAM system port: CPU (req 0) has fixed
// priority, the drawing engine (req 1) is protected by a saturating wait counter.
module vram_arb #(
    parameter int ADDRW    = 14,
    parameter int WORD     = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic             clk_sys,
    input  logic             rst_sys_n,

    input  logic             req0,
    input  logic             re0,
    input  logic [WORD-1:0]  wmask0,
    input  logic [ADDRW-1:0] addr0,
    input  logic [WORD-1:0]  din0,
    output logic             gnt0,
    output logic             rvalid0,
    output logic [WORD-1:0]  rdata0,

    input  logic             req1,
    input  logic             re1,
    input  logic [WORD-1:0]  wmask1,
    input  logic [ADDRW-1:0] addr1,
    input  logic [WORD-1:0]  din1,
    output logic             gnt1,
    output logic             rvalid1,
    output logic [WORD-1:0]  rdata1,

    output logic             vram_re,
    output logic [WORD-1:0]  vram_wmask,
    output logic [ADDRW-1:0] vram_addr,
    output logic [WORD-1:0]  vram_din,
    input  logic [WORD-1:0]  vram_dout
);

    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    logic [7:0] wait_cnt;
    logic       rv_s1, rv_s2;
    logic       tag_s1, tag_s2;

    // Grants are held off while reset is asserted so nothing is accepted then.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_sys_n) begin
            if (req1 && wait_cnt == MAX_W)
                gnt1 = 1'b1;
            else if (req0)
                gnt0 = 1'b1;
            else if (req1)
                gnt1 = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            wait_cnt <= '0;
        end else if (req1 && !gnt1) begin
            if (wait_cnt != MAX_W)
                wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Idle cycles clear re/wmask only; address and data keep their last value.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            vram_re    <= 1'b0;
            vram_wmask <= '0;
            vram_addr  <= '0;
            vram_din   <= '0;
        end else if (gnt0) begin
            vram_re    <= re0;
            vram_wmask <= wmask0;
            vram_addr  <= addr0;
            vram_din   <= din0;
        end else if (gnt1) begin
            vram_re    <= re1;
            vram_wmask <= wmask1;
            vram_addr  <= addr1;
            vram_din   <= din1;
        end else begin
            vram_re    <= 1'b0;
            vram_wmask <= '0;
        end
    end

    // Read-return pipeline: stage 1 aligns with the RAM command, stage 2 with dout.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            rv_s1  <= 1'b0;
            tag_s1 <= 1'b0;
            rv_s2  <= 1'b0;
            tag_s2 <= 1'b0;
        end else begin
            rv_s1  <= (gnt0 && re0) || (gnt1 && re1);
            tag_s1 <= gnt1;
            rv_s2  <= rv_s1;
            tag_s2 <= tag_s1;
        end
    end

    assign rvalid0 = rv_s2 && !tag_s2;
    assign rvalid1 = rv_s2 && tag_s2;
    assign rdata0  = vram_dout;
    assign rdata1  = vram_dout;

endmodule

// File: tb/tb_vram_arb.sv
// Scoreboard bench for vram_arb: a RAM model, a reference arbiter/memory, and
// an expected read-return queue compared as rvalid pulses appear.
module tb_vram_arb;

    localparam int ADDRW = 14;
    localparam int WORD  = 32;
    localparam int MW    = 2;

    logic             clk_sys = 1'b0;
    logic             rst_sys_n = 1'b0;
    logic             req0 = 1'b0, re0 = 1'b0, req1 = 1'b0, re1 = 1'b0;
    logic [WORD-1:0]  wmask0 = '0, din0 = '0, wmask1 = '0, din1 = '0;
    logic [ADDRW-1:0] addr0 = '0, addr1 = '0;
    logic             gnt0, gnt1, rvalid0, rvalid1;
    logic [WORD-1:0]  rdata0, rdata1;
    logic             vram_re;
    logic [WORD-1:0]  vram_wmask, vram_din;
    logic [ADDRW-1:0] vram_addr;
    logic [WORD-1:0]  vram_dout = '0;

    vram_arb #(.ADDRW(ADDRW), .WORD(WORD), .MAX_WAIT(MW)) dut (
        .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
        .req0(req0), .re0(re0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .re1(re1), .wmask1(wmask1), .addr1(addr1), .din1(din1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .vram_re(vram_re), .vram_wmask(vram_wmask), .vram_addr(vram_addr),
        .vram_din(vram_din), .vram_dout(vram_dout)
    );

    always #5 clk_sys = ~clk_sys;

    logic [WORD-1:0] ram  [0:(1<<ADDRW)-1];
    logic [WORD-1:0] refm [0:(1<<ADDRW)-1];

    // Video RAM model: registered read, read-before-write, bit-masked write.
    always @(posedge clk_sys) begin
        if (vram_re)
            vram_dout <= ram[vram_addr];
        ram[vram_addr] <= (ram[vram_addr] & ~vram_wmask) | (vram_din & vram_wmask);
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int              who;
        logic [WORD-1:0] data;
        int              due;
    } rd_t;

    rd_t             q[$];
    int              cyc = 0;
    int              wc  = 0;
    logic            exp_vre = 1'b0;
    logic [ADDRW-1:0] exp_vaddr = '0;

    always @(negedge clk_sys) begin
        logic eg0, eg1, ev0, ev1;
        logic [ADDRW-1:0] a;
        cyc++;
        if (!rst_sys_n) begin
            chk("rst_gnt0", gnt0, 0);
            chk("rst_gnt1", gnt1, 0);
            chk("rst_rv", {rvalid1, rvalid0}, 0);
            chk("rst_vram", {vram_re, vram_wmask, vram_addr}, 0);
            chk("rst_vdin", vram_din, 0);
            q.delete();
            wc = 0;
            exp_vre = 1'b0;
        end else begin
            eg1 = req1 && (wc == MW || !req0);
            eg0 = req0 && !eg1;
            chk("gnt0", gnt0, eg0);
            chk("gnt1", gnt1, eg1);
            chk("one_gnt", gnt0 & gnt1, 0);
            chk("vram_re", vram_re, exp_vre);
            if (exp_vre)
                chk("vram_addr", vram_addr, exp_vaddr);
            ev0 = q.size() > 0 && q[0].due == cyc && q[0].who == 0;
            ev1 = q.size() > 0 && q[0].due == cyc && q[0].who == 1;
            chk("rvalid0", rvalid0, ev0);
            chk("rvalid1", rvalid1, ev1);
            if (ev0) chk("rdata0", rdata0, q[0].data);
            if (ev1) chk("rdata1", rdata1, q[0].data);
            if (ev0 || ev1) void'(q.pop_front());
            exp_vre = 1'b0;
            if (eg0 || eg1) begin
                a = eg0 ? addr0 : addr1;
                exp_vre = eg0 ? re0 : re1;
                exp_vaddr = a;
                if (exp_vre)
                    q.push_back('{who: eg0 ? 0 : 1, data: refm[a], due: cyc + 2});
                if (eg0) refm[a] = (refm[a] & ~wmask0) | (din0 & wmask0);
                else     refm[a] = (refm[a] & ~wmask1) | (din1 & wmask1);
            end
            if (req1 && !eg1) wc = (wc < MW) ? wc + 1 : MW;
            else              wc = 0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic cmd(input int r, input logic re, input logic [WORD-1:0] wm,
                       input logic [ADDRW-1:0] a, input logic [WORD-1:0] d);
        bit got;
        got = 0;
        if (r == 0) begin req0 = 1; re0 = re; wmask0 = wm; addr0 = a; din0 = d; end
        else        begin req1 = 1; re1 = re; wmask1 = wm; addr1 = a; din1 = d; end
        for (int n = 0; n < 32 && !got; n++) begin
            @(negedge clk_sys);
            got = (r == 0) ? gnt0 : gnt1;
        end
        if (!got) chk("gnt_timeout", 0, 1);
        @(posedge clk_sys);
        #1;
        if (r == 0) req0 = 0; else req1 = 0;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDRW); i++) begin
            ram[i]  = 32'h0100_0000 ^ i;
            refm[i] = 32'h0100_0000 ^ i;
        end
        ram['h10] = 32'hDEADBEEF; refm['h10] = 32'hDEADBEEF;
        ram['h20] = 32'hAAAAAAAA; refm['h20] = 32'hAAAAAAAA;
        for (int i = 0; i < 4; i++) begin
            ram[i]  = 32'hC0DE_0000 + 32'(i * 17);
            refm[i] = 32'hC0DE_0000 + 32'(i * 17);
        end

        req0 = 1; req1 = 1; re0 = 1; re1 = 1;
        repeat (3) @(posedge clk_sys);
        #1;
        rst_sys_n = 1;
        req0 = 0; req1 = 0; re0 = 0; re1 = 0;
        idle(2);

        cmd(0, 1, '0, 14'h0010, '0);
        idle(4);

        cmd(1, 0, 32'h0000FFFF, 14'h0020, 32'h12345678);
        cmd(1, 1, '0, 14'h0020, '0);
        idle(4);
        chk("wr_merge", ram['h20], 32'hAAAA5678);

        for (int i = 0; i < 4; i++)
            cmd(0, 1, '0, 14'(i), '0);
        idle(4);

        req0 = 1; re0 = 1; addr0 = 14'h5; wmask0 = '0;
        req1 = 1; re1 = 1; addr1 = 14'h6; wmask1 = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_sys);
            chk("pat_g0", gnt0, (i % 3) != 2);
            chk("pat_g1", gnt1, (i % 3) == 2);
        end
        @(posedge clk_sys);
        #1;
        req0 = 0; req1 = 0;
        idle(4);

        req0 = 1; re0 = 1; addr0 = 14'h10;
        req1 = 1; re1 = 1; addr1 = 14'h6;
        @(negedge clk_sys);
        chk("pre_rst_gnt0", gnt0, 1);
        @(posedge clk_sys);
        #1;
        req0 = 0; req1 = 0;
        rst_sys_n = 0;
        @(posedge clk_sys);
        #1;
        rst_sys_n = 1;
        req0 = 1; req1 = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_sys);
            if (i == 0) chk("rst_flush_rv0", rvalid0, 0);
            chk("restart_g1", gnt1, i == 2);
        end
        @(posedge clk_sys);
        #1;
        req0 = 0; req1 = 0;
        idle(5);
        chk("drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
